// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed common-anode seven-segment scanner with per-frame data capture.
// Registered SEL/SEG advance one digit per scan tick; frame data and blink mask latch at each frame start.
module seg_scan_driver #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_FREQ   = 1000,
  parameter int BLINK_TICKS = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic [7:0]  Blink_mask,
  output logic [7:0]  SEL,
  output logic [7:0]  SEG
);

  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [CW-1:0] presc_cnt;
  logic [2:0]    idx;
  logic [31:0]   frame_buf;
  logic [7:0]    mask_buf;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          tick;
  logic          frame_start;
  logic          blink_wrap;
  logic [2:0]    idx_nxt;
  logic [31:0]   frame_nxt;
  logic [7:0]    mask_nxt;
  logic          phase_nxt;
  logic [3:0]    nib;
  logic          dark;
  logic [7:0]    sel_nxt;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'hBF;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign tick        = (presc_cnt == DIV_LAST);
  assign frame_start = (idx == 3'd7);
  assign blink_wrap  = (blink_cnt == BLINK_LAST);

  // Outputs are computed from the post-tick view so the new digit uses the frame
  // and blink phase that become current on this same edge.
  always_comb begin
    idx_nxt   = frame_start ? 3'd0 : idx + 3'd1;
    frame_nxt = frame_start ? Data : frame_buf;
    mask_nxt  = frame_start ? Blink_mask : mask_buf;
    phase_nxt = blink_wrap ? ~phase : phase;
    nib       = frame_nxt[{idx_nxt, 2'b00} +: 4];
    dark      = mask_nxt[idx_nxt] & phase_nxt;
    sel_nxt   = 8'hFF;
    seg_nxt   = 8'hFF;
    if (!dark) begin
      sel_nxt = ~(8'h01 << idx_nxt);
      seg_nxt = decode(nib);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_cnt <= '0;
      idx       <= 3'd7;
      frame_buf <= '0;
      mask_buf  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      SEL       <= 8'hFF;
      SEG       <= 8'hFF;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        idx       <= idx_nxt;
        frame_buf <= frame_nxt;
        mask_buf  <= mask_nxt;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        phase     <= phase_nxt;
        SEL       <= sel_nxt;
        SEG       <= seg_nxt;
      end
    end
  end

endmodule
